m_axil_master: RTL and testbench

Parametrised AXI4-Lite master controller for the tDMA datapath. It is the successor to the single-transaction write/read controller: it carries address/data/strobe, supports up to `MAX_OUT` outstanding transactions per direction, and issues AW and W independently. It also captures the first error (SLVERR/DECERR or response timeout) with its address. It sits between the tDMA command logic (FIFO side, internal memory side) and the AXI4-Lite interconnect.

---
 rtl/m_axil_pkg.sv | 27 ++
 rtl/axil_addr_track_fifo.sv | 54 +++++
 rtl/m_axil_master.sv | 202 ++++++++++++++++++++
 tb/tb_m_axil_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_axil_pkg.sv
// Shared types for the AXI4-Lite master: response and error codes.
// Also holds the default protection value and a response-error helper.
package m_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_W_RESP    = 3'd1,
    ERR_R_RESP    = 3'd2,
    ERR_W_TIMEOUT = 3'd3,
    ERR_R_TIMEOUT = 3'd4
  } err_code_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both have bit 1 set; EXOKAY counts as OKAY.
  function automatic logic resp_is_err(input logic [1:0] r);
    return r[1];
  endfunction

endpackage

// File: rtl/axil_addr_track_fifo.sv
// Address tracking FIFO: remembers the address of each outstanding txn.
// Ports: clk, rst (sync high), push/push_data, pop, head, empty, full.
module axil_addr_track_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

endmodule

// File: rtl/m_axil_master.sv
// AXI4-Lite master: write/read command in, AXI-Lite out, first-error capture.
// Ports: wcmd/rcmd cmd handshakes, rsp read data, AW/W/B/AR/R, err status.
module m_axil_master
  import m_axil_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic              wcmd_valid_i,
  output logic              wcmd_ready_o,
  input  logic [ADDR_W-1:0] wcmd_addr_i,
  input  logic [DATA_W-1:0] wcmd_data_i,
  input  logic [STRB_W-1:0] wcmd_strb_i,
  input  logic              rcmd_valid_i,
  output logic              rcmd_ready_o,
  input  logic [ADDR_W-1:0] rcmd_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              write_complete_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [2:0]        awprot_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  input  logic              bvalid_i,
  output logic              bready_o,
  input  logic [1:0]        bresp_i,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [2:0]        arprot_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  output logic              err_o,
  output logic [2:0]        err_code_o,
  output logic [ADDR_W-1:0] err_addr_o,
  input  logic              err_clear_i
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam bit            TO_EN   = (TIMEOUT_CYC > 0);

  logic aw_pend, w_pend, ar_pend;
  logic wr_empty, wr_full, rd_empty, rd_full;
  logic [ADDR_W-1:0] wr_head, rd_head;
  logic wr_acc, rd_acc;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [TW-1:0] wto_cnt, rto_cnt;
  logic wto_ev, rto_ev;
  err_code_e ev_code;
  logic [ADDR_W-1:0] ev_addr;

  // Command readys are held low during reset so nothing is accepted then.
  assign wcmd_ready_o = !areset_i && !aw_pend && !w_pend && !wr_full;
  assign rcmd_ready_o = !areset_i && !ar_pend && !rd_full;

  assign awvalid_o = aw_pend;
  assign wvalid_o  = w_pend;
  assign arvalid_o = ar_pend;
  assign awprot_o  = AXI_PROT_DEFAULT;
  assign arprot_o  = AXI_PROT_DEFAULT;

  assign bready_o = !wr_empty;
  assign rready_o = !rd_empty && (!rsp_valid_o || rsp_ready_i);

  assign wr_acc = wcmd_valid_i && wcmd_ready_o;
  assign rd_acc = rcmd_valid_i && rcmd_ready_o;
  assign aw_hs  = awvalid_o && awready_i;
  assign w_hs   = wvalid_o && wready_i;
  assign b_hs   = bvalid_i && bready_o;
  assign ar_hs  = arvalid_o && arready_i;
  assign r_hs   = rvalid_i && rready_o;

  axil_addr_track_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_wr_fifo (
    .clk       (aclk_i),
    .rst       (areset_i),
    .push      (wr_acc),
    .push_data (wcmd_addr_i),
    .pop       (b_hs),
    .head      (wr_head),
    .empty     (wr_empty),
    .full      (wr_full)
  );

  axil_addr_track_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_rd_fifo (
    .clk       (aclk_i),
    .rst       (areset_i),
    .push      (rd_acc),
    .push_data (rcmd_addr_i),
    .pop       (r_hs),
    .head      (rd_head),
    .empty     (rd_empty),
    .full      (rd_full)
  );

  // Timeout fires once, on the step that reaches TIMEOUT_CYC.
  assign wto_ev = TO_EN && !b_hs && !wr_empty && (wto_cnt == TO_LAST);
  assign rto_ev = TO_EN && !r_hs && !rd_empty && (rto_cnt == TO_LAST);

  always_comb begin
    ev_code = ERR_NONE;
    ev_addr = '0;
    if (b_hs && resp_is_err(bresp_i)) begin
      ev_code = ERR_W_RESP;
      ev_addr = wr_head;
    end else if (r_hs && resp_is_err(rresp_i)) begin
      ev_code = ERR_R_RESP;
      ev_addr = rd_head;
    end else if (wto_ev) begin
      ev_code = ERR_W_TIMEOUT;
      ev_addr = wr_head;
    end else if (rto_ev) begin
      ev_code = ERR_R_TIMEOUT;
      ev_addr = rd_head;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      aw_pend          <= 1'b0;
      w_pend           <= 1'b0;
      ar_pend          <= 1'b0;
      awaddr_o         <= '0;
      wdata_o          <= '0;
      wstrb_o          <= '0;
      araddr_o         <= '0;
      write_complete_o <= 1'b0;
      rsp_valid_o      <= 1'b0;
      rsp_data_o       <= '0;
      rsp_err_o        <= 1'b0;
      wto_cnt          <= '0;
      rto_cnt          <= '0;
      err_o            <= 1'b0;
      err_code_o       <= ERR_NONE;
      err_addr_o       <= '0;
    end else begin
      if (wr_acc) begin
        awaddr_o <= wcmd_addr_i;
        wdata_o  <= wcmd_data_i;
        wstrb_o  <= wcmd_strb_i;
        aw_pend  <= 1'b1;
        w_pend   <= 1'b1;
      end else begin
        if (aw_hs) aw_pend <= 1'b0;
        if (w_hs)  w_pend  <= 1'b0;
      end

      if (rd_acc) begin
        araddr_o <= rcmd_addr_i;
        ar_pend  <= 1'b1;
      end else if (ar_hs) begin
        ar_pend <= 1'b0;
      end

      write_complete_o <= b_hs;

      if (r_hs) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= rdata_i;
        rsp_err_o   <= resp_is_err(rresp_i);
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end

      if (b_hs || wr_empty)
        wto_cnt <= '0;
      else if (TO_EN && wto_cnt != TO_MAX)
        wto_cnt <= wto_cnt + 1'b1;

      if (r_hs || rd_empty)
        rto_cnt <= '0;
      else if (TO_EN && rto_cnt != TO_MAX)
        rto_cnt <= rto_cnt + 1'b1;

      // A clear in the same cycle as a new error yields the new error.
      if (ev_code != ERR_NONE && (!err_o || err_clear_i)) begin
        err_o      <= 1'b1;
        err_code_o <= ev_code;
        err_addr_o <= ev_addr;
      end else if (err_clear_i) begin
        err_o      <= 1'b0;
        err_code_o <= ERR_NONE;
        err_addr_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_m_axil_master.sv
// Directed self-checking bench for m_axil_master.
// MAX_OUT=4, TIMEOUT_CYC=16; steps are driven 1ns after each rising edge.
module tb_m_axil_master;

  logic        aclk_i = 1'b0;
  logic        areset_i;
  logic        wcmd_valid_i, wcmd_ready_o;
  logic [31:0] wcmd_addr_i, wcmd_data_i;
  logic [3:0]  wcmd_strb_i;
  logic        rcmd_valid_i, rcmd_ready_o;
  logic [31:0] rcmd_addr_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_data_o;
  logic        write_complete_o;
  logic        awvalid_o, awready_i;
  logic [31:0] awaddr_o;
  logic [2:0]  awprot_o;
  logic        wvalid_o, wready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        bvalid_i, bready_o;
  logic [1:0]  bresp_i;
  logic        arvalid_o, arready_i;
  logic [31:0] araddr_o;
  logic [2:0]  arprot_o;
  logic        rvalid_i, rready_o;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        err_o, err_clear_i;
  logic [2:0]  err_code_o;
  logic [31:0] err_addr_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  m_axil_master #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .TIMEOUT_CYC(16)
  ) dut (
    .aclk_i(aclk_i), .areset_i(areset_i),
    .wcmd_valid_i(wcmd_valid_i), .wcmd_ready_o(wcmd_ready_o),
    .wcmd_addr_i(wcmd_addr_i), .wcmd_data_i(wcmd_data_i),
    .wcmd_strb_i(wcmd_strb_i),
    .rcmd_valid_i(rcmd_valid_i), .rcmd_ready_o(rcmd_ready_o),
    .rcmd_addr_i(rcmd_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .write_complete_o(write_complete_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .araddr_o(araddr_o), .arprot_o(arprot_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rdata_i(rdata_i), .rresp_i(rresp_i),
    .err_o(err_o), .err_code_o(err_code_o),
    .err_addr_o(err_addr_o), .err_clear_i(err_clear_i)
  );

  always #5 aclk_i = ~aclk_i;

  task automatic step();
    @(posedge aclk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_i = 1; err_clear_i = 0;
    wcmd_valid_i = 0; wcmd_addr_i = 0; wcmd_data_i = 0; wcmd_strb_i = 0;
    rcmd_valid_i = 0; rcmd_addr_i = 0; rsp_ready_i = 1;
    awready_i = 1; wready_i = 1; arready_i = 1;
    bvalid_i = 0; bresp_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0;

    // Reset state
    repeat (3) step();
    chk("rst_wcmd_rdy", wcmd_ready_o, 0);
    chk("rst_rcmd_rdy", rcmd_ready_o, 0);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_bready", bready_o, 0);
    chk("rst_rready", rready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_code", err_code_o, 0);
    chk("rst_awaddr", awaddr_o, 0);
    chk("rst_prot", {awprot_o, arprot_o}, 0);
    areset_i = 0;
    step();
    chk("idle_wcmd_rdy", wcmd_ready_o, 1);

    // Single write, zero-wait slave
    wcmd_valid_i = 1; wcmd_addr_i = 32'h100;
    wcmd_data_i = 32'hDEADBEEF; wcmd_strb_i = 4'hF;
    #1 chk("w1_ready", wcmd_ready_o, 1);
    step();
    wcmd_valid_i = 0;
    chk("w1_awvalid", awvalid_o, 1);
    chk("w1_wvalid", wvalid_o, 1);
    chk("w1_awaddr", awaddr_o, 32'h100);
    chk("w1_wdata", wdata_o, 32'hDEADBEEF);
    chk("w1_wstrb", wstrb_o, 4'hF);
    chk("w1_bready", bready_o, 1);
    step();
    chk("w1_aw_done", awvalid_o, 0);
    chk("w1_w_done", wvalid_o, 0);
    chk("w1_ready_again", wcmd_ready_o, 1);
    bvalid_i = 1; bresp_i = 2'd0;
    step();
    bvalid_i = 0;
    chk("w1_wc_pulse", write_complete_o, 1);
    step();
    chk("w1_wc_once", write_complete_o, 0);
    chk("w1_no_err", err_o, 0);

    // AW before W: W held off for 3 cycles
    wready_i = 0;
    wcmd_valid_i = 1; wcmd_addr_i = 32'h200;
    wcmd_data_i = 32'h11223344; wcmd_strb_i = 4'h3;
    step();
    wcmd_valid_i = 0;
    step();
    chk("aw1st_aw_drop", awvalid_o, 0);
    chk("aw1st_w_held", wvalid_o, 1);
    chk("aw1st_wdata", wdata_o, 32'h11223344);
    chk("aw1st_rdy_lo", wcmd_ready_o, 0);
    step();
    chk("aw1st_w_held2", wvalid_o, 1);
    chk("aw1st_rdy_lo2", wcmd_ready_o, 0);
    wready_i = 1;
    step();
    chk("aw1st_w_done", wvalid_o, 0);
    chk("aw1st_rdy_hi", wcmd_ready_o, 1);
    bvalid_i = 1;
    step();
    bvalid_i = 0;
    chk("aw1st_wc", write_complete_o, 1);

    // Outstanding limit: four writes without B, fifth stalls
    for (int i = 0; i < 4; i++) begin
      wcmd_valid_i = 1; wcmd_addr_i = 32'h300 + i * 4;
      wcmd_data_i = i; wcmd_strb_i = 4'hF;
      #1 chk("lim_accept", wcmd_ready_o, 1);
      step();
      wcmd_valid_i = 0;
      step();
    end
    wcmd_valid_i = 1; wcmd_addr_i = 32'h310; wcmd_data_i = 32'h5;
    #1 chk("lim_5th_stall", wcmd_ready_o, 0);
    step();
    step();
    chk("lim_5th_stall2", wcmd_ready_o, 0);
    chk("lim_no_aw", awvalid_o, 0);
    bvalid_i = 1;
    #1 chk("lim_bready", bready_o, 1);
    step();
    bvalid_i = 0;
    chk("lim_first_b_wc", write_complete_o, 1);
    chk("lim_rdy_after_b", wcmd_ready_o, 1);
    step();
    wcmd_valid_i = 0;
    chk("lim_5th_aw", awvalid_o, 1);
    chk("lim_5th_addr", awaddr_o, 32'h310);
    step();
    bvalid_i = 1;
    repeat (4) step();
    bvalid_i = 0;
    chk("lim_drained", bready_o, 0);
    chk("lim_last_wc", write_complete_o, 1);

    // Read backpressure: two reads, rsp_ready low
    rsp_ready_i = 0;
    rcmd_valid_i = 1; rcmd_addr_i = 32'h500;
    step();
    rcmd_valid_i = 0;
    chk("rd_arvalid", arvalid_o, 1);
    chk("rd_araddr", araddr_o, 32'h500);
    step();
    rcmd_valid_i = 1; rcmd_addr_i = 32'h504;
    #1 chk("rd2_ready", rcmd_ready_o, 1);
    step();
    rcmd_valid_i = 0;
    step();
    rvalid_i = 1; rdata_i = 32'hA; rresp_i = 2'd0;
    #1 chk("rd_rready", rready_o, 1);
    step();
    rdata_i = 32'hB;
    chk("rd_rsp_a_valid", rsp_valid_o, 1);
    chk("rd_rsp_a_data", rsp_data_o, 32'hA);
    chk("rd_rready_drop", rready_o, 0);
    step();
    chk("rd_rsp_a_hold", rsp_data_o, 32'hA);
    rsp_ready_i = 1;
    step();
    rvalid_i = 0;
    chk("rd_rsp_b_valid", rsp_valid_o, 1);
    chk("rd_rsp_b_data", rsp_data_o, 32'hB);
    step();
    chk("rd_rsp_empty", rsp_valid_o, 0);
    chk("rd_rready_idle", rready_o, 0);

    // Error capture: B SLVERR and R DECERR in the same cycle
    wcmd_valid_i = 1; wcmd_addr_i = 32'h40;
    step();
    wcmd_valid_i = 0;
    step();
    rcmd_valid_i = 1; rcmd_addr_i = 32'h80;
    step();
    rcmd_valid_i = 0;
    step();
    bvalid_i = 1; bresp_i = 2'd2;
    rvalid_i = 1; rresp_i = 2'd3; rdata_i = 32'h55;
    step();
    bvalid_i = 0; rvalid_i = 0; bresp_i = 0; rresp_i = 0;
    chk("err_flag", err_o, 1);
    chk("err_code_w", err_code_o, 3'd1);
    chk("err_addr_w", err_addr_o, 32'h40);
    chk("err_rsp_err", rsp_err_o, 1);
    chk("err_rsp_data", rsp_data_o, 32'h55);
    rcmd_valid_i = 1; rcmd_addr_i = 32'h90;
    step();
    rcmd_valid_i = 0;
    step();
    rvalid_i = 1; rresp_i = 2'd2;
    step();
    rvalid_i = 0; rresp_i = 0;
    chk("err_kept_code", err_code_o, 3'd1);
    chk("err_kept_addr", err_addr_o, 32'h40);
    err_clear_i = 1;
    step();
    err_clear_i = 0;
    chk("clr_err", err_o, 0);
    chk("clr_code", err_code_o, 0);
    chk("clr_addr", err_addr_o, 0);

    // Read timeout after 16 cycles outstanding, then late response
    rcmd_valid_i = 1; rcmd_addr_i = 32'hC0;
    step();
    rcmd_valid_i = 0;
    repeat (15) step();
    chk("to_not_yet", err_o, 0);
    step();
    chk("to_err", err_o, 1);
    chk("to_code", err_code_o, 3'd4);
    chk("to_addr", err_addr_o, 32'hC0);
    rvalid_i = 1; rdata_i = 32'hCAFE; rresp_i = 2'd0;
    step();
    rvalid_i = 0;
    chk("late_r_valid", rsp_valid_o, 1);
    chk("late_r_data", rsp_data_o, 32'hCAFE);
    chk("late_r_ok", rsp_err_o, 0);
    chk("late_r_code", err_code_o, 3'd4);
    step();
    chk("late_r_drained", rready_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
